maze_wall_map: RTL
==================

# maze_wall_map

Writable, parametrised wall store for the maze: one horizontal-wall plane of (MAP_H+1) rows × MAP_W bits and one vertical-wall plane of MAP_H rows × (MAP_W+1) bits. After reset it self-initialises to a border-only maze, then accepts row writes from the level loader. It answers single-cell movement queries ("is the wall in direction d of cell (x,y) set?") for the player/collision logic and serves registered row reads to the renderer. It replaces the fixed 8×7 / 7×8 combinational wall tables.

## Interface
Parameters:
- MAP_W, 7, maze width in cells
- MAP_H, 7, maze height in cells
- LOCK_BORDER, 1, when 1 outer-border wall bits are forced to 1 on every write
- Derived: XW = $clog2(MAP_W+1), YW = $clog2(MAP_H+1), DW = MAP_W+1

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- init  in  1  pulse in READY: re-run border initialisation
- busy  out  1  high while initialising
- wr_valid  in  1  row write request
- wr_ready  out  1  write accepted when wr_valid & wr_ready
- wr_sel  in  1  0 = horizontal plane, 1 = vertical plane
- wr_row  in  YW+1  target row
- wr_data  in  DW  bit i = column i; horizontal writes use bits [MAP_W-1:0]
- wr_err  out  1  one-cycle pulse: accepted write had an out-of-range row
- q_valid  in  1  query request
- q_ready  out  1  query accepted when q_valid & q_ready
- q_x  in  XW  cell column
- q_y  in  YW  cell row
- q_dir  in  2  0 = N, 1 = E, 2 = S, 3 = W
- r_valid  out  1  query response strobe
- r_blocked  out  1  1 = wall present or cell out of range
- rd_sel  in  1  renderer plane select
- rd_row  in  YW+1  renderer row
- rd_data  out  DW  registered row contents, unused MSB zero for horizontal plane

## Operation
- FSM states: CLEAR, READY. rst → CLEAR with row counter = 0. init in READY → CLEAR. init in CLEAR is ignored.
- CLEAR: each cycle writes row r of both planes: horizontal row r = all ones if r == 0 or r == MAP_H, else zero; vertical row r (r < MAP_H) = bit 0 and bit MAP_W set, others zero. After r == MAP_H → READY.
- busy = 1 in CLEAR. wr_ready = q_ready = 0 in CLEAR, 1 in READY.
- Write: horizontal rows valid 0..MAP_H, vertical rows valid 0..MAP_H-1. Out-of-range row: no storage change, handshake completes, wr_err pulses the next cycle.
- LOCK_BORDER = 1: horizontal rows 0 and MAP_H are written as all ones; vertical bits 0 and MAP_W are written as 1.
- Query mapping:
  - N → H[q_y][q_x]
  - S → H[q_y+1][q_x]
  - W → V[q_y][q_x]
  - E → V[q_y][q_x+1]
  - q_x ≥ MAP_W or q_y ≥ MAP_H → blocked = 1.
- A write and a query in the same cycle: the query sees the pre-write contents (read-before-write). The renderer read behaves the same way.

## Timing
- Reset values: busy = 1, wr_ready = 0, q_ready = 0, r_valid = 0, r_blocked = 0, wr_err = 0, rd_data = 0.
- Initialisation takes MAP_H+1 cycles; busy falls on the cycle READY is entered.
- Query latency is 1: r_valid and r_blocked are registered the cycle after acceptance. r_valid is a single-cycle strobe. Back-to-back queries are allowed, one per cycle.
- Writes take effect at the clock edge of acceptance and are visible to queries accepted the following cycle.
- rd_data is registered with 1-cycle latency. It is always active, including during CLEAR, where it returns the partially initialised contents. An out-of-range rd_row returns 0.
- rst mid-CLEAR or mid-stream restarts CLEAR from row 0. No in-flight response survives: r_valid is 0 the cycle after rst.

## Structure
- Add to params.vh: MAP_W/MAP_H defaults, the direction encodings (DIR_N, DIR_E, DIR_S, DIR_W) and the plane-select encodings.
- Storage is two flop arrays. No block RAM, because the query and render ports need independent single-cycle reads.
- One sub-module, wall_plane (parametrised rows × cols, one write port, two registered read ports), instanced once per plane.
- The FSM, border generation and query decode live in the top level.

## Test plan
- Reset → busy high for 8 cycles (default params), then READY. Read H row 0 = 7'b1111111, H row 3 = 0, V row 2 = 8'b10000001.
- After init, write V row 3 = 8'b00010000. Query (x=3, y=3, E) → r_blocked = 1 one cycle later. Query (3, 3, W) → 0. Query (4, 3, W) → 1.
- Query (0, 0, N) → 1. Query (7, 2, N) → 1 (out of range). Query (2, 2, S) on an empty interior → 0.
- LOCK_BORDER = 1: write H row 0 = 0 → row reads back 7'b1111111. Write V row 4 = 0 → reads back 8'b10000001.
- Write H row 9 → handshake completes, wr_err pulses, no row changes. Same-cycle write and query of the same bit → response is the old value; the repeated query the next cycle returns the new value.
- Assert rst mid-CLEAR (cycle 4) and mid-query → r_valid = 0 the next cycle, busy asserted, and a full 8-cycle re-initialisation follows. init pulsed in READY → busy for 8 cycles and interior writes cleared.

Source files
------------

// File: rtl/maze_wall_map_pkg.sv
// maze_wall_map_pkg
//   Shared definitions for the maze wall store: default maze size, the
//   movement-direction and plane-select encodings, and the controller states.
package maze_wall_map_pkg;

  localparam int MAP_W_DEF = 7;  // maze width in cells
  localparam int MAP_H_DEF = 7;  // maze height in cells

  // Direction of a movement query, relative to the queried cell.
  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_S = 2'd2,
    DIR_W = 2'd3
  } dir_e;

  // Wall plane selection for the write and renderer ports.
  typedef enum logic {
    PLANE_H = 1'b0,  // horizontal walls, (MAP_H+1) rows x MAP_W bits
    PLANE_V = 1'b1   // vertical walls, MAP_H rows x (MAP_W+1) bits
  } plane_e;

  // Controller states.
  typedef enum logic {
    ST_CLEAR = 1'b0,  // writing the border-only maze one row per cycle
    ST_READY = 1'b1   // accepting writes and queries
  } state_e;

endpackage

// File: rtl/maze_wall_map_if.sv
// maze_wall_map_if
//   Bundles every non-clock/reset signal of the wall store.
//   master : level loader / player logic / renderer side
//   slave  : the wall store itself
//   Groups: init/busy control, row write (wr_*), movement query (q_*) with
//   its response (r_*), and the renderer row read (rd_*).
interface maze_wall_map_if
  import maze_wall_map_pkg::*;
#(
  parameter int MAP_W = MAP_W_DEF,
  parameter int MAP_H = MAP_H_DEF
);

  localparam int XW = $clog2(MAP_W + 1);
  localparam int YW = $clog2(MAP_H + 1);
  localparam int DW = MAP_W + 1;
  localparam int RW = YW + 1;

  logic          init;
  logic          busy;

  logic          wr_valid;
  logic          wr_ready;
  logic          wr_sel;
  logic [RW-1:0] wr_row;
  logic [DW-1:0] wr_data;
  logic          wr_err;

  logic          q_valid;
  logic          q_ready;
  logic [XW-1:0] q_x;
  logic [YW-1:0] q_y;
  logic [1:0]    q_dir;
  logic          r_valid;
  logic          r_blocked;

  logic          rd_sel;
  logic [RW-1:0] rd_row;
  logic [DW-1:0] rd_data;

  modport master (
    output init, wr_valid, wr_sel, wr_row, wr_data,
           q_valid, q_x, q_y, q_dir, rd_sel, rd_row,
    input  busy, wr_ready, wr_err, q_ready, r_valid, r_blocked, rd_data
  );

  modport slave (
    input  init, wr_valid, wr_sel, wr_row, wr_data,
           q_valid, q_x, q_y, q_dir, rd_sel, rd_row,
    output busy, wr_ready, wr_err, q_ready, r_valid, r_blocked, rd_data
  );

endinterface

// File: rtl/maze_wall_map_wall_plane.sv
// wall_plane
//   One wall plane held in flops: ROWS rows of COLS bits, one write port and
//   NRD independent registered read ports.
//   clk, rst            : clock, synchronous active-high reset (read regs only)
//   we, waddr, wdata    : row write; addresses >= ROWS are ignored
//   ren[p], raddr[p]    : read port p, row captured on the clock edge when
//                         ren[p] is high; addresses >= ROWS read as zero
//   rdata[p]            : registered row for port p
//   A read and a write of the same row on the same edge return the old row.
module wall_plane #(
  parameter int ROWS = 8,
  parameter int COLS = 7,
  parameter int AW   = 4,
  parameter int NRD  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [AW-1:0]             waddr,
  input  logic [COLS-1:0]           wdata,
  input  logic [NRD-1:0]            ren,
  input  logic [NRD-1:0][AW-1:0]    raddr,
  output logic [NRD-1:0][COLS-1:0]  rdata
);

  // Contents are established by the owner's initialisation sweep, so the
  // storage itself carries no reset.
  logic [COLS-1:0] mem_reg [ROWS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < ROWS; i++) begin
      if (we && (waddr == AW'(i))) begin
        mem_reg[i] <= wdata;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [COLS-1:0] rdata_next;
      logic [COLS-1:0] rdata_reg;

      // Full-compare mux so out-of-range rows fall through to zero.
      always_comb begin
        rdata_next = '0;
        for (int i = 0; i < ROWS; i++) begin
          if (raddr[gi] == AW'(i)) begin
            rdata_next = mem_reg[i];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_reg <= '0;
        end else if (ren[gi]) begin
          rdata_reg <= rdata_next;
        end
      end

      assign rdata[gi] = rdata_reg;
    end
  endgenerate

endmodule

// File: rtl/maze_wall_map.sv
// maze_wall_map
//   Writable wall store for the maze: a horizontal plane H of (MAP_H+1) rows
//   x MAP_W bits and a vertical plane V of MAP_H rows x (MAP_W+1) bits.
//   After reset (or init) it sweeps one row per cycle writing a border-only
//   maze, then accepts loader row writes, single-cell movement queries and
//   renderer row reads.
//   clk, rst : clock, synchronous active-high reset
//   bus      : maze_wall_map_if slave
//     init/busy           : re-initialise request (READY only) / sweep active
//     wr_* / wr_err       : row write handshake, bad-row pulse one cycle later
//     q_* / r_*           : movement query, 1-cycle registered response
//     rd_sel/rd_row/rd_data : registered renderer row read, always active
module maze_wall_map
  import maze_wall_map_pkg::*;
#(
  parameter int MAP_W       = MAP_W_DEF,
  parameter int MAP_H       = MAP_H_DEF,
  parameter int LOCK_BORDER = 1
) (
  input  logic            clk,
  input  logic            rst,
  maze_wall_map_if.slave  bus
);

  localparam int XW = $clog2(MAP_W + 1);
  localparam int YW = $clog2(MAP_H + 1);
  localparam int DW = MAP_W + 1;
  localparam int RW = YW + 1;

  localparam logic [MAP_W-1:0] H_ONES   = {MAP_W{1'b1}};
  localparam logic [DW-1:0]    V_BORDER = {1'b1, {(DW - 2){1'b0}}, 1'b1};

  // Controller state and registered outputs.
  state_e        state_reg;
  logic [RW-1:0] row_reg;
  logic          busy_reg;
  logic          ready_reg;
  logic          wr_err_reg;
  logic          r_valid_reg;

  // Query context captured at acceptance, used to pick the response bit.
  logic [XW-1:0] qbit_reg;
  logic          qh_reg;
  logic          qoor_reg;
  logic          rd_sel_reg;

  // Handshakes.
  logic wr_acc;
  logic q_acc;
  logic wr_row_oor;

  assign wr_acc = bus.wr_valid & ready_reg;
  assign q_acc  = bus.q_valid & ready_reg;

  // H accepts rows 0..MAP_H, V accepts rows 0..MAP_H-1.
  assign wr_row_oor = (bus.wr_sel == PLANE_V) ? (bus.wr_row >= RW'(MAP_H))
                                              : (bus.wr_row >  RW'(MAP_H));

  // ---------------------------------------------------------------------
  // Write port steering: the initialisation sweep owns both planes while
  // clearing, otherwise an accepted in-range loader write goes to one plane.
  // ---------------------------------------------------------------------
  logic             h_we;
  logic [RW-1:0]    h_waddr;
  logic [MAP_W-1:0] h_wdata;
  logic             v_we;
  logic [RW-1:0]    v_waddr;
  logic [DW-1:0]    v_wdata;

  always_comb begin
    h_we    = 1'b0;
    h_waddr = row_reg;
    h_wdata = '0;
    v_we    = 1'b0;
    v_waddr = row_reg;
    v_wdata = V_BORDER;
    if (state_reg == ST_CLEAR) begin
      h_we    = 1'b1;
      h_wdata = ((row_reg == '0) || (row_reg == RW'(MAP_H))) ? H_ONES : '0;
      // The last sweep step only has an H row to write.
      v_we    = (row_reg < RW'(MAP_H));
    end else if (wr_acc && !wr_row_oor) begin
      if (bus.wr_sel == PLANE_V) begin
        v_we    = 1'b1;
        v_waddr = bus.wr_row;
        v_wdata = bus.wr_data | ((LOCK_BORDER != 0) ? V_BORDER : '0);
      end else begin
        h_we    = 1'b1;
        h_waddr = bus.wr_row;
        h_wdata = bus.wr_data[MAP_W-1:0];
        if ((LOCK_BORDER != 0) &&
            ((bus.wr_row == '0) || (bus.wr_row == RW'(MAP_H)))) begin
          h_wdata = H_ONES;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Query decode. N/S look at the H plane (row y or y+1), E/W at the V plane
  // row y (column x or x+1). The row is fetched through read port 0 and the
  // bit is chosen from the registered row on the response cycle.
  // ---------------------------------------------------------------------
  logic          q_is_h;
  logic          q_oor;
  logic [RW-1:0] q_hrow;
  logic [RW-1:0] q_vrow;
  logic [XW-1:0] q_bit;

  assign q_is_h = (bus.q_dir == DIR_N) || (bus.q_dir == DIR_S);
  assign q_oor  = (bus.q_x >= XW'(MAP_W)) || (bus.q_y >= YW'(MAP_H));
  assign q_hrow = {1'b0, bus.q_y} + ((bus.q_dir == DIR_S) ? RW'(1) : RW'(0));
  assign q_vrow = {1'b0, bus.q_y};
  assign q_bit  = (bus.q_dir == DIR_E) ? (bus.q_x + XW'(1)) : bus.q_x;

  // ---------------------------------------------------------------------
  // Planes: read port 0 serves queries, port 1 the renderer.
  // ---------------------------------------------------------------------
  logic [1:0][MAP_W-1:0] h_rd;
  logic [1:0][DW-1:0]    v_rd;

  wall_plane #(
    .ROWS (MAP_H + 1),
    .COLS (MAP_W),
    .AW   (RW),
    .NRD  (2)
  ) u_hplane (
    .clk   (clk),
    .rst   (rst),
    .we    (h_we),
    .waddr (h_waddr),
    .wdata (h_wdata),
    .ren   ({1'b1, q_acc}),
    .raddr ({bus.rd_row, q_hrow}),
    .rdata (h_rd)
  );

  wall_plane #(
    .ROWS (MAP_H),
    .COLS (DW),
    .AW   (RW),
    .NRD  (2)
  ) u_vplane (
    .clk   (clk),
    .rst   (rst),
    .we    (v_we),
    .waddr (v_waddr),
    .wdata (v_wdata),
    .ren   ({1'b1, q_acc}),
    .raddr ({bus.rd_row, q_vrow}),
    .rdata (v_rd)
  );

  // ---------------------------------------------------------------------
  // Controller FSM and registered strobes.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_CLEAR;
      row_reg     <= '0;
      busy_reg    <= 1'b1;
      ready_reg   <= 1'b0;
      wr_err_reg  <= 1'b0;
      r_valid_reg <= 1'b0;
      qbit_reg    <= '0;
      qh_reg      <= 1'b0;
      qoor_reg    <= 1'b0;
      rd_sel_reg  <= 1'b0;
    end else begin
      wr_err_reg  <= wr_acc & wr_row_oor;
      r_valid_reg <= q_acc;
      rd_sel_reg  <= bus.rd_sel;
      if (q_acc) begin
        qbit_reg <= q_bit;
        qh_reg   <= q_is_h;
        qoor_reg <= q_oor;
      end
      case (state_reg)
        ST_CLEAR: begin
          // init is deliberately not looked at here.
          if (row_reg == RW'(MAP_H)) begin
            state_reg <= ST_READY;
            row_reg   <= '0;
            busy_reg  <= 1'b0;
            ready_reg <= 1'b1;
          end else begin
            row_reg <= row_reg + RW'(1);
          end
        end
        ST_READY: begin
          if (bus.init) begin
            state_reg <= ST_CLEAR;
            row_reg   <= '0;
            busy_reg  <= 1'b1;
            ready_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_CLEAR;
          row_reg   <= '0;
          busy_reg  <= 1'b1;
          ready_reg <= 1'b0;
        end
      endcase
    end
  end

  // Response and renderer outputs are pure selections of registered values.
  logic [DW-1:0] q_row_ext;

  assign q_row_ext     = qh_reg ? {1'b0, h_rd[0]} : v_rd[0];
  assign bus.r_blocked = qoor_reg | q_row_ext[qbit_reg];
  assign bus.rd_data   = rd_sel_reg ? v_rd[1] : {1'b0, h_rd[1]};

  assign bus.busy      = busy_reg;
  assign bus.wr_ready  = ready_reg;
  assign bus.q_ready   = ready_reg;
  assign bus.wr_err    = wr_err_reg;
  assign bus.r_valid   = r_valid_reg;

endmodule
